// File: rtl/div_pkg.sv
// Shared definitions for the divider front-end: opcodes, FSM states,
// default iteration count and result field positions.
package div_pkg;

    // Divider opcodes
    localparam logic [5:0] DIV_NOP  = 6'b000000;
    localparam logic [5:0] DIV_DIVU = 6'b011011;
    localparam logic [5:0] DIV_OUT  = 6'b111111;

    // Iterations the divider needs for a 32-bit operand
    localparam int DIV_ITER_DEFAULT = 32;

    // Field positions in the divider's 64-bit dataOut after OUT
    localparam int REM_MSB  = 63;
    localparam int REM_LSB  = 32;
    localparam int QUOT_MSB = 31;
    localparam int QUOT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SHIFT,
        CAPT,
        RESP
    } div_state_t;

endpackage

// File: rtl/div_sequencer_rr_arb2.sv
// Two-port round-robin arbiter. A lone requester is granted directly.
// When both request, the port that was not granted last wins. The
// pointer moves only when the granted request is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr = 0 favours port 0, ptr = 1 favours port 1
    logic ptr;

    // Combinational grant from the request vector and the pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant is taken, favour the port that was not served
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Front-end controller for the iterative 32-bit unsigned divider.
// It arbitrates between two requesters and keeps one division in
// flight. It sequences the divider through DIVU iterations and the
// final OUT shift, then returns quotient/remainder tagged with the
// requester id.
// Optional build macro DIVZERO_BYPASS_EN: adds resp_err and answers a
// zero divisor directly from IDLE without running the divider.
module div_sequencer
    import div_pkg::*;
#(
    parameter int ITER_CYCLES = DIV_ITER_DEFAULT,
    parameter int PORTS       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_quot,
    output logic [31:0] resp_rem,
`ifdef DIVZERO_BYPASS_EN
    output logic        resp_err,
`endif
    output logic [5:0]  div_signal,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_reset,
    input  logic [63:0] div_result
);

    localparam int CNT_W = $clog2(ITER_CYCLES + 1);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic [PORTS-1:0] grant;
    logic             hs;
    logic             last_iter;
    logic             zero_div;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant)
    );

    assign hs        = (state_q == IDLE) && (|(req_valid & grant));
    assign sel_a     = grant[1] ? req_a1 : req_a0;
    assign sel_b     = grant[1] ? req_b1 : req_b0;
    assign last_iter = (cnt == CNT_W'(ITER_CYCLES - 1));
`ifdef DIVZERO_BYPASS_EN
    assign zero_div  = (sel_b == 32'd0);
`else
    assign zero_div  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        div_signal = DIV_NOP;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (hs) begin
                    state_d = zero_div ? RESP : RUN;
                end
            end
            RUN: begin
                div_signal = DIV_DIVU;
                if (last_iter) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_signal = DIV_OUT;
                state_d    = CAPT;
            end
            CAPT: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration counter and divider reset pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            div_reset <= 1'b1;
        end else begin
            div_reset <= 1'b0;
            if (hs) begin
                cnt <= '0;
            end else if (state_q == RUN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Operand and id capture on the request handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            div_a   <= '0;
            div_b   <= '0;
            resp_id <= 1'b0;
        end else if (hs) begin
            div_a   <= sel_a;
            div_b   <= sel_b;
            resp_id <= grant[1];
        end
    end

    // Response payload: divider result in CAPT, or the zero-divisor answer
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_quot <= '0;
            resp_rem  <= '0;
`ifdef DIVZERO_BYPASS_EN
            resp_err  <= 1'b0;
`endif
        end else if (state_q == CAPT) begin
            resp_rem  <= div_result[REM_MSB:REM_LSB];
            resp_quot <= div_result[QUOT_MSB:QUOT_LSB];
        end else if (hs && zero_div) begin
            resp_quot <= 32'hFFFF_FFFF;
            resp_rem  <= sel_a;
`ifdef DIVZERO_BYPASS_EN
            resp_err  <= 1'b1;
        end else if (hs) begin
            resp_err  <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Front-end controller for the iterative 32-bit unsigned divider.
- Arbitrates round-robin between two requesters and keeps one division outstanding at a time.
- Drives the divider's opcode, operand and reset lines: load/iterate with DIVU, then the final OUT shift.
- Captures the 64-bit result and returns quotient/remainder on a valid/ready response channel tagged with the requester id.

Parameters:
ITER_CYCLES, 32, number of consecutive clk cycles div_signal is held at DIVU.
PORTS, 2, number of requesters (fixed at 2; the parameter is documentation only).

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-port request valid
req_ready  output  2  per-port request ready (at most one bit high)
req_a0, req_a1  input  32 each  dividend, port 0 / port 1
req_b0, req_b1  input  32 each  divisor, port 0 / port 1
resp_valid  output  1  response valid
resp_ready  input  1  response accepted by consumer
resp_id  output  1  port that issued the request
resp_quot  output  32  quotient
resp_rem  output  32  remainder
div_signal  output  6  divider opcode: NOP 6'b000000, DIVU 6'b011011, OUT 6'b111111
div_a  output  32  divider dataA (registered)
div_b  output  32  divider dataB (registered)
div_reset  output  1  divider reset
div_result  input  64  divider dataOut; [63:32] remainder, [31:0] quotient after OUT

Behaviour:
- States: IDLE, RUN, SHIFT, CAPT, RESP.
- Reset values:
  - state IDLE
  - div_signal NOP, div_reset 1 for the reset cycle and 0 afterwards
  - div_a/div_b 0
  - resp_valid 0, resp_quot/resp_rem/resp_id 0
  - round-robin pointer favours port 0
  - iteration counter 0
- IDLE:
  - Grant is combinational from req_valid and the pointer. If one valid, grant it. If both valid, grant the port not granted last.
  - req_ready[g] = 1 only for the granted port; both bits are 0 in every other state.
  - On handshake: latch operands into div_a/div_b, latch id, flip the pointer to the other port, go to RUN, counter cleared.
- RUN: div_signal=DIVU for exactly ITER_CYCLES cycles; counter increments each cycle; after the last cycle go to SHIFT.
- SHIFT: div_signal=OUT for one cycle, then go to CAPT.
- CAPT: div_signal=NOP; register resp_rem=div_result[63:32], resp_quot=div_result[31:0]; go to RESP.
- RESP:
  - resp_valid=1; outputs held stable until resp_ready.
  - On the resp_valid&resp_ready cycle go to IDLE; a new request can be accepted the next cycle.
- Latency: handshake at edge N; resp_valid high from edge N+ITER_CYCLES+3. Throughput is one division per ITER_CYCLES+4 cycles minimum.
- div_a/div_b are stable from RUN through CAPT; requester inputs may change after their handshake.
- Divisor 0 without the optional feature: no special case. The divider returns quot=32'hFFFFFFFF, rem=dividend.
- reset in any state, including mid-RUN or while resp_valid is held: return to IDLE next edge, drop resp_valid, pulse div_reset. The in-flight result is discarded with no response.
- A request that deasserts req_valid before handshake is simply not granted; no state change.

Optional Feature:
DIVZERO_BYPASS_EN:
- Defined:
  - Adds output resp_err (1 bit, reset 0).
  - A granted request with divisor==0 skips RUN/SHIFT/CAPT. It goes IDLE->RESP in one cycle with quot=32'hFFFFFFFF, rem=dividend, resp_err=1; div_signal stays NOP.
  - resp_err=0 for all other responses.
- Undefined: resp_err does not exist; divisor 0 takes the normal full-latency path.

Decomposition:
- Shared package div_pkg:
  - opcode constants DIV_NOP, DIV_DIVU, DIV_OUT
  - state enum (IDLE, RUN, SHIFT, CAPT, RESP)
  - DIV_ITER_DEFAULT=32
  - result field slices (REM_MSB/LSB, QUOT_MSB/LSB)
- Sub-module: rr_arb2, the two-port round-robin arbiter (req[1:0], advance, grant[1:0], pointer register).

Test Plan:
- Port 0 issues 100/7, resp_ready=1 -> resp_valid at edge N+35, resp_id=0, quot=14, rem=2; div_signal sequence 32xDIVU, 1xOUT, NOP.
- Both ports valid in the same cycle (port0 0xFFFFFFFF/1, port1 1000/10) -> port0 served first (quot=0xFFFFFFFF, rem=0), then port1 (quot=100, rem=0); third simultaneous request goes to port0 again.
- resp_ready held low 5 cycles after resp_valid -> outputs stable, req_ready=2'b00 throughout, accept resumes the cycle after handshake.
- reset asserted at RUN counter=10 -> next cycle IDLE, resp_valid=0, div_reset=1 for one cycle; a fresh 9/4 then returns quot=2, rem=1.
- 5/0 without DIVZERO_BYPASS_EN -> full latency, quot=0xFFFFFFFF, rem=5.
- 5/0 with DIVZERO_BYPASS_EN -> resp_valid at edge N+1, quot=0xFFFFFFFF, rem=5, resp_err=1, no DIVU issued.
